// File: rtl/accelerator_dnc_pkg.sv
// Shared definitions for the DNC write-head datapath: FSM states, fixed-point
// defaults and the wide multiply-shift used by the erase/write element.
package accelerator_dnc_pkg;

  localparam int FRACTION_SIZE_DEF = 16;
  localparam longint unsigned ONE_DEF = 64'd1 << FRACTION_SIZE_DEF;

  // Widest supported element; products are formed at twice this width.
  localparam int MAX_DW = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WEIGHT,
    ROW,
    DONE
  } state_t;

  // Full-width product shifted right with truncation; the 2*MAX_DW result
  // cannot overflow for MAX_DW-bit operands.
  function automatic logic [2*MAX_DW-1:0] mul_shift(input logic [MAX_DW-1:0] x,
                                                    input logic [MAX_DW-1:0] y,
                                                    input int unsigned frac);
    logic [2*MAX_DW-1:0] prod;
    prod = {{MAX_DW{1'b0}}, x} * {{MAX_DW{1'b0}}, y};
    return prod >> frac;
  endfunction

endpackage

// File: rtl/accelerator_memory_erase_write_if.sv
// Handshake and data bundle between the write-head stages, the memory store
// and the erase/write block.
interface accelerator_memory_erase_write_if #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
);
  logic                    START;
  logic                    READY;
  logic                    E_IN_ENABLE;
  logic                    W_IN_ENABLE;
  logic                    M_IN_ENABLE;
  logic                    M_OUT_ENABLE;
  logic [CONTROL_SIZE-1:0] SIZE_N_IN;
  logic [CONTROL_SIZE-1:0] SIZE_W_IN;
  logic [DATA_SIZE-1:0]    E_IN;
  logic [DATA_SIZE-1:0]    A_IN;
  logic [DATA_SIZE-1:0]    W_IN;
  logic [DATA_SIZE-1:0]    M_IN;
  logic [DATA_SIZE-1:0]    M_OUT;

  modport master (
    output START, E_IN_ENABLE, W_IN_ENABLE, M_IN_ENABLE,
    output SIZE_N_IN, SIZE_W_IN, E_IN, A_IN, W_IN, M_IN,
    input  READY, M_OUT_ENABLE, M_OUT
  );

  modport slave (
    input  START, E_IN_ENABLE, W_IN_ENABLE, M_IN_ENABLE,
    input  SIZE_N_IN, SIZE_W_IN, E_IN, A_IN, W_IN, M_IN,
    output READY, M_OUT_ENABLE, M_OUT
  );
endinterface

// File: rtl/accelerator_erase_write_element.sv
// One memory element update M' = M*(1 - w*e) + w*a in fixed point, with a
// registered, saturated result. DATA_SIZE must not exceed MAX_DW.
module accelerator_erase_write_element
  import accelerator_dnc_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int FRACTION_SIZE = FRACTION_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc,
  input  logic [DATA_SIZE-1:0] w,
  input  logic [DATA_SIZE-1:0] e,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] m,
  output logic                 vld,
  output logic [DATA_SIZE-1:0] m_out
);

  localparam int PW = 2 * MAX_DW;
  localparam logic [PW-1:0] ONE = PW'(1) << FRACTION_SIZE;

  function automatic logic [DATA_SIZE-1:0] saturate(input logic [PW:0] v);
    if (v > (PW+1)'({DATA_SIZE{1'b1}})) return '1;
    return v[DATA_SIZE-1:0];
  endfunction

  logic [PW-1:0]        p_p0;
  logic [MAX_DW-1:0]    f_p0;
  logic [PW:0]          r_p0;
  logic [DATA_SIZE-1:0] m_next_p0;
  logic                 vld_p1;
  logic [DATA_SIZE-1:0] m_p1;

  // Stage 0: combinational erase factor and sum, clamped at ONE and at full scale.
  always_comb begin
    p_p0      = mul_shift(MAX_DW'(w), MAX_DW'(e), FRACTION_SIZE);
    f_p0      = (p_p0 > ONE) ? '0 : MAX_DW'(ONE - p_p0);
    r_p0      = (PW+1)'(mul_shift(MAX_DW'(m), f_p0, FRACTION_SIZE))
              + (PW+1)'(mul_shift(MAX_DW'(w), MAX_DW'(a), FRACTION_SIZE));
    m_next_p0 = saturate(r_p0);
  end

  // Stage 1: output register; the value holds between accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      m_p1   <= '0;
    end else begin
      vld_p1 <= acc;
      if (acc) m_p1 <= m_next_p0;
    end
  end

  assign vld   = vld_p1;
  assign m_out = m_p1;

endmodule

// File: rtl/accelerator_memory_erase_write.sv
// DNC write-head memory update: buffers e/a for one word, then streams the
// N x W memory row by row against each row's write weight.
module accelerator_memory_erase_write
  import accelerator_dnc_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int FRACTION_SIZE = FRACTION_SIZE_DEF,
  parameter int MAX_W         = 64
) (
  input logic CLK,
  input logic RST,
  accelerator_memory_erase_write_if.slave bus
);

  localparam int IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  state_t                  state, state_next;
  logic [CONTROL_SIZE-1:0] size_n, size_w, j, k, w_clamp;
  logic [DATA_SIZE-1:0]    e_buf [MAX_W];
  logic [DATA_SIZE-1:0]    a_buf [MAX_W];
  logic [DATA_SIZE-1:0]    w_j;
  logic [IDX_W-1:0]        k_idx;
  logic                    last_k, last_j, beat_e, beat_m;

  assign w_clamp = (bus.SIZE_W_IN > CONTROL_SIZE'(MAX_W)) ? CONTROL_SIZE'(MAX_W)
                                                            : bus.SIZE_W_IN;
  assign k_idx   = k[IDX_W-1:0];
  assign last_k  = (k == size_w - CONTROL_SIZE'(1));
  assign last_j  = (j == size_n - CONTROL_SIZE'(1));
  assign beat_e  = (state == LOAD) && bus.E_IN_ENABLE;
  assign beat_m  = (state == ROW) && bus.M_IN_ENABLE;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.START)
              state_next = (bus.SIZE_N_IN == '0 || w_clamp == '0) ? DONE : LOAD;
      LOAD:   if (beat_e && last_k) state_next = WEIGHT;
      WEIGHT: if (bus.W_IN_ENABLE) state_next = ROW;
      ROW:    if (beat_m && last_k) state_next = last_j ? DONE : WEIGHT;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.READY = (state == DONE);
  end

  // Sizes are captured once per run; k walks the word, j walks the rows.
  always_ff @(posedge CLK) begin
    if (RST) begin
      size_n <= '0;
      size_w <= '0;
      j      <= '0;
      k      <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.START) begin
          size_n <= bus.SIZE_N_IN;
          size_w <= w_clamp;
          j      <= '0;
          k      <= '0;
        end
        LOAD: if (beat_e) k <= last_k ? '0 : k + CONTROL_SIZE'(1);
        ROW: if (beat_m) begin
          if (last_k) begin
            k <= '0;
            if (!last_j) j <= j + CONTROL_SIZE'(1);
          end else begin
            k <= k + CONTROL_SIZE'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (beat_e) begin
      e_buf[k_idx] <= bus.E_IN;
      a_buf[k_idx] <= bus.A_IN;
    end
    if (state == WEIGHT && bus.W_IN_ENABLE) w_j <= bus.W_IN;
  end

  accelerator_erase_write_element #(
    .DATA_SIZE     (DATA_SIZE),
    .FRACTION_SIZE (FRACTION_SIZE)
  ) u_element (
    .clk   (CLK),
    .rst   (RST),
    .acc   (beat_m),
    .w     (w_j),
    .e     (e_buf[k_idx]),
    .a     (a_buf[k_idx]),
    .m     (bus.M_IN),
    .vld   (bus.M_OUT_ENABLE),
    .m_out (bus.M_OUT)
  );

endmodule

// File: tb/tb_accelerator_memory_erase_write.sv
// Randomized and directed bench for the erase/write block against a
// behavioural model of the fixed-point update rule.
module tb_accelerator_memory_erase_write;
  localparam int DS = 16, CS = 16, FS = 8, MW = 8;
  localparam longint unsigned ONE = 256;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  accelerator_memory_erase_write_if #(.DATA_SIZE(DS), .CONTROL_SIZE(CS)) bus();

  accelerator_memory_erase_write #(
    .DATA_SIZE(DS), .CONTROL_SIZE(CS), .FRACTION_SIZE(FS), .MAX_W(MW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0, bad = 0;
  int oe_cnt = 0, rdy_cnt = 0;
  logic [DS-1:0] e_v [MW], a_v [MW], w_v [4];
  logic [DS-1:0] m_v [4][MW];
  logic [DS-1:0] got_q [$];
  logic [DS-1:0] saved_q [$];

  always @(negedge CLK) begin
    if (bus.M_OUT_ENABLE === 1'b1) oe_cnt++;
    if (bus.READY === 1'b1) rdy_cnt++;
  end

  function automatic logic [DS-1:0] model(longint unsigned w, longint unsigned e,
                                          longint unsigned a, longint unsigned m);
    longint unsigned p, f, r;
    p = (w * e) >> FS;
    f = (p > ONE) ? 0 : ONE - p;
    r = ((m * f) >> FS) + ((w * a) >> FS);
    return (r > 65535) ? 16'hFFFF : r[DS-1:0];
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idle_in();
    bus.START = 0; bus.E_IN_ENABLE = 0; bus.W_IN_ENABLE = 0; bus.M_IN_ENABLE = 0;
    bus.E_IN = '0; bus.A_IN = '0; bus.W_IN = '0; bus.M_IN = '0;
  endtask

  // Idle cycles; in random mode the enables that do not belong to the current
  // phase (and START) are toggled with junk data, which must be ignored.
  task automatic gap(input int gmode, input int phase);
    int n;
    n = (gmode == 1) ? 2 : (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (n) begin
      if (gmode == 2) begin
        bus.START       = 1'($urandom);
        bus.E_IN_ENABLE = (phase != 0) && 1'($urandom);
        bus.W_IN_ENABLE = (phase != 1) && 1'($urandom);
        bus.M_IN_ENABLE = (phase != 2) && 1'($urandom);
        bus.E_IN = 16'($urandom); bus.A_IN = 16'($urandom);
        bus.W_IN = 16'($urandom); bus.M_IN = 16'($urandom);
      end
      tick();
      idle_in();
    end
  endtask

  task automatic run_op(input int n, input int wsz, input int gmode,
                        input int abort_at, input bit sid, input string tag);
    int weff, beat, oe0, rd0;
    logic [DS-1:0] exp_v;
    weff = (wsz > MW) ? MW : wsz;
    beat = 0;
    got_q.delete();
    #1; oe0 = oe_cnt; rd0 = rdy_cnt;
    bus.SIZE_N_IN = CS'(n); bus.SIZE_W_IN = CS'(wsz); bus.START = 1;
    tick();
    bus.START = 0;
    if (n == 0 || weff == 0) begin
      tick(); tick(); #1;
      total++; if (rdy_cnt - rd0 !== 1) begin bad++; $display("FAIL %s ready_pulses: got %0d want 1", tag, rdy_cnt - rd0); end
      total++; if (oe_cnt - oe0 !== 0) begin bad++; $display("FAIL %s out_beats: got %0d want 0", tag, oe_cnt - oe0); end
      return;
    end
    for (int kk = 0; kk < weff; kk++) begin
      gap(gmode, 0);
      bus.E_IN_ENABLE = 1; bus.E_IN = e_v[kk]; bus.A_IN = a_v[kk];
      tick();
      idle_in();
    end
    for (int jj = 0; jj < n; jj++) begin
      gap(gmode, 1);
      bus.W_IN_ENABLE = 1; bus.W_IN = w_v[jj];
      tick();
      idle_in();
      for (int kk = 0; kk < weff; kk++) begin
        if (beat == abort_at) begin
          bus.M_IN_ENABLE = 1; bus.M_IN = 16'($urandom); RST = 1;
          tick();
          idle_in();
          total++; if (bus.M_OUT_ENABLE !== 1'b0) begin bad++; $display("FAIL %s rst_oe: got %b want 0", tag, bus.M_OUT_ENABLE); end
          total++; if (bus.M_OUT !== '0) begin bad++; $display("FAIL %s rst_mout: got %0d want 0", tag, bus.M_OUT); end
          total++; if (bus.READY !== 1'b0) begin bad++; $display("FAIL %s rst_ready: got %b want 0", tag, bus.READY); end
          RST = 0;
          repeat (4) tick();
          #1;
          total++; if (rdy_cnt - rd0 !== 0) begin bad++; $display("FAIL %s abort_ready: got %0d want 0", tag, rdy_cnt - rd0); end
          return;
        end
        gap(gmode, 2);
        bus.M_IN_ENABLE = 1; bus.M_IN = m_v[jj][kk];
        tick();
        idle_in();
        exp_v = model(w_v[jj], e_v[kk], a_v[kk], m_v[jj][kk]);
        total++;
        if (bus.M_OUT_ENABLE !== 1'b1 || bus.M_OUT !== exp_v) begin
          bad++;
          $display("FAIL %s beat j=%0d k=%0d: got en=%b val=%0d want en=1 val=%0d",
                   tag, jj, kk, bus.M_OUT_ENABLE, bus.M_OUT, exp_v);
        end
        got_q.push_back(bus.M_OUT);
        if (jj == n - 1 && kk == weff - 1) begin
          total++; if (bus.READY !== 1'b1) begin bad++; $display("FAIL %s ready_at_end: got %b want 1", tag, bus.READY); end
        end
        beat++;
      end
    end
    if (sid) begin
      bus.START = 1; bus.SIZE_N_IN = '0; bus.SIZE_W_IN = CS'(1);
      tick();
      total++; if (bus.READY !== 1'b0) begin bad++; $display("FAIL %s start_in_done: got %b want 0", tag, bus.READY); end
      tick();
      total++; if (bus.READY !== 1'b1) begin bad++; $display("FAIL %s start_after_done: got %b want 1", tag, bus.READY); end
      bus.START = 0;
    end else begin
      tick();
      total++; if (bus.READY !== 1'b0) begin bad++; $display("FAIL %s ready_width: got %b want 0", tag, bus.READY); end
    end
    tick(); #1;
    total++; if (rdy_cnt - rd0 !== (sid ? 2 : 1)) begin bad++; $display("FAIL %s ready_pulses: got %0d want %0d", tag, rdy_cnt - rd0, sid ? 2 : 1); end
    total++; if (oe_cnt - oe0 !== n * weff) begin bad++; $display("FAIL %s out_beats: got %0d want %0d", tag, oe_cnt - oe0, n * weff); end
  endtask

  task automatic check_got(input int idx, input logic [DS-1:0] want, input string tag);
    logic [DS-1:0] g;
    g = (idx < got_q.size()) ? got_q[idx] : 'x;
    total++;
    if (g !== want) begin bad++; $display("FAIL %s[%0d]: got %0d want %0d", tag, idx, g, want); end
  endtask

  task automatic load_matrix();
    e_v[0] = 256; e_v[1] = 0; e_v[2] = 128;
    for (int i = 0; i < 3; i++) a_v[i] = 0;
    w_v[0] = 256; w_v[1] = 0;
    m_v[0][0] = 10; m_v[0][1] = 20; m_v[0][2] = 30;
    m_v[1][0] = 40; m_v[1][1] = 50; m_v[1][2] = 60;
  endtask

  task automatic single(input logic [DS-1:0] e, input logic [DS-1:0] a,
                        input logic [DS-1:0] w, input logic [DS-1:0] m,
                        input logic [DS-1:0] want, input string tag);
    e_v[0] = e; a_v[0] = a; w_v[0] = w; m_v[0][0] = m;
    run_op(1, 1, 0, -1, 0, tag);
    check_got(0, want, tag);
  endtask

  task automatic test_reset();
    idle_in();
    bus.SIZE_N_IN = '0; bus.SIZE_W_IN = '0;
    RST = 1;
    tick(); tick();
    total++; if (bus.READY !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.READY); end
    total++; if (bus.M_OUT_ENABLE !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", bus.M_OUT_ENABLE); end
    total++; if (bus.M_OUT !== '0) begin bad++; $display("FAIL reset_mout: got %0d want 0", bus.M_OUT); end
    RST = 0;
    tick();
  endtask

  task automatic test_single();
    single(256, 0, 256, 100, 0, "full_erase");
    single(256, 77, 0, 100, 100, "no_write");
    single(128, 64, 256, 200, 164, "mixed_w1");
    single(128, 64, 128, 200, 182, "mixed_w_half");
  endtask

  task automatic test_matrix();
    logic [DS-1:0] want [6];
    want = '{0, 20, 15, 40, 50, 60};
    load_matrix();
    run_op(2, 3, 1, -1, 0, "matrix");
    for (int i = 0; i < 6; i++) check_got(i, want[i], "matrix");
    saved_q = got_q;
  endtask

  task automatic test_bounds();
    run_op(0, 3, 0, -1, 0, "n_zero");
    for (int i = 0; i < MW; i++) begin
      e_v[i] = 16'($urandom_range(0, 300)); a_v[i] = 16'($urandom);
      m_v[0][i] = 16'($urandom);
    end
    w_v[0] = 16'($urandom_range(0, 300));
    run_op(1, MW + 5, 0, -1, 0, "w_clamp");
    single(0, 256, 256, 16'hFFFF, 16'hFFFF, "saturate");
  endtask

  task automatic test_random();
    for (int op = 0; op < 8; op++) begin
      int n, wsz;
      n = int'($urandom_range(1, 3));
      wsz = int'($urandom_range(1, MW + 2));
      for (int i = 0; i < MW; i++) begin
        e_v[i] = $urandom_range(0, 1) ? 16'($urandom_range(0, 600)) : 16'($urandom);
        a_v[i] = 16'($urandom);
      end
      for (int jj = 0; jj < 4; jj++) begin
        w_v[jj] = $urandom_range(0, 1) ? 16'($urandom_range(0, 512)) : 16'($urandom);
        for (int i = 0; i < MW; i++) m_v[jj][i] = 16'($urandom);
      end
      run_op(n, wsz, 2, -1, 0, "random");
    end
  endtask

  task automatic test_reset_mid();
    load_matrix();
    run_op(2, 3, 0, 4, 0, "abort");
    run_op(2, 3, 0, -1, 0, "after_abort");
    total++;
    if (got_q != saved_q) begin bad++; $display("FAIL after_abort_vs_clean: got %0d beats want %0d identical", got_q.size(), saved_q.size()); end
  endtask

  task automatic test_back_to_back();
    e_v[0] = 64; a_v[0] = 10; w_v[0] = 512; m_v[0][0] = 1000;
    run_op(1, 1, 0, -1, 1, "start_in_done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_matrix();
    test_bounds();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
